// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : parity modes, receiver FSM encoding and width helper
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] BREAK  = 3'd6;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// uart_sync2 : two-flop synchroniser with configurable reset level
// Rev 1.0
// ============================================================================
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// uart_rx_param : parametrised UART receiver with error flags and handshake
// Rev 1.0
// ============================================================================
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  import uart_pkg::*;

  localparam int                CNT_W       = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  c_half_load = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  c_full_load = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0]        c_last_stop = 4'(STOP_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 fe_acc_q, fe_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 commit_w;
  logic                 tick_w;
  logic                 par_err_w;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign tick_w = (cnt_q == '0);

  // par_acc holds the XOR of data bits and the received parity bit.
  generate
    if (PARITY == int'(PAR_ODD)) begin : g_par_odd
      assign par_err_w = ~par_acc_q;
    end else if (PARITY == int'(PAR_EVEN)) begin : g_par_even
      assign par_err_w = par_acc_q;
    end else begin : g_par_none
      assign par_err_w = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_acc_d = par_acc_q;
    fe_acc_d  = fe_acc_q;
    commit_w  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          cnt_d     = c_half_load;
          bit_d     = '0;
          par_acc_d = 1'b0;
          fe_acc_d  = 1'b0;
        end
      end
      START: begin
        if (tick_w) begin
          state_d = rx_s ? IDLE : DATA;
          cnt_d   = c_full_load;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (tick_w) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ rx_s;
          cnt_d     = c_full_load;
          if (bit_q == c_last_data) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? uart_pkg::PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      uart_pkg::PARITY: begin
        if (tick_w) begin
          par_acc_d = par_acc_q ^ rx_s;
          cnt_d     = c_full_load;
          bit_d     = '0;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (tick_w) begin
          if (!rx_s) fe_acc_d = 1'b1;
          cnt_d = c_full_load;
          if (bit_q == c_last_stop) begin
            state_d = DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        commit_w = 1'b1;
        // A low line after a bad stop is a break; hold off until it releases.
        state_d  = (fe_acc_q && !rx_s) ? BREAK : IDLE;
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake is evaluated first, so an accept frees the slot for a commit.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = 1'b0;
    if (commit_w && (!valid_q || ready)) begin
      data_d  = shift_q;
      ferr_d  = fe_acc_q;
      perr_d  = par_err_w;
      valid_d = 1'b1;
    end else if (commit_w) begin
      ovr_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
      fe_acc_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_acc_q <= par_acc_d;
      fe_acc_q  <= fe_acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_param : directed + random frames on three receiver configurations
// Rev 1.0
// ============================================================================
module tb_uart_rx_param;

  localparam int CPB   = 10;
  localparam int C_LAT = 2 + CPB / 2 + 9 * CPB + 2;

  logic       clk;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] ready;

  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [2:0] valid_w, fe_w, pe_w, ovr_w, busy_w;
  logic [8:0] data_w [3];

  assign data_w[0] = {1'b0, d0};
  assign data_w[1] = {2'b00, d1};
  assign data_w[2] = {1'b0, d2};

  uart_rx_param u_def (
    .clk (clk), .rst (rst), .rx (rx[0]), .data_out (d0), .valid (valid_w[0]),
    .ready (ready[0]), .frame_err (fe_w[0]), .parity_err (pe_w[0]),
    .overrun (ovr_w[0]), .busy (busy_w[0])
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY(2)) u_par (
    .clk (clk), .rst (rst), .rx (rx[1]), .data_out (d1), .valid (valid_w[1]),
    .ready (ready[1]), .frame_err (fe_w[1]), .parity_err (pe_w[1]),
    .overrun (ovr_w[1]), .busy (busy_w[1])
  );

  uart_rx_param #(.STOP_BITS(2)) u_stop2 (
    .clk (clk), .rst (rst), .rx (rx[2]), .data_out (d2), .valid (valid_w[2]),
    .ready (ready[2]), .frame_err (fe_w[2]), .parity_err (pe_w[2]),
    .overrun (ovr_w[2]), .busy (busy_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event recorder: valid rising edges capture the word, overrun pulses are counted.
  int         cyc = 0;
  int         vrise [3] = '{0, 0, 0};
  int         ovr_cnt [3] = '{0, 0, 0};
  int         rise_cyc [3] = '{0, 0, 0};
  logic [8:0] cap_data [3];
  logic       cap_fe [3];
  logic       cap_pe [3];
  logic       vprev [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (valid_w[k] && !vprev[k]) begin
        vrise[k]++;
        cap_data[k] = data_w[k];
        cap_fe[k]   = fe_w[k];
        cap_pe[k]   = pe_w[k];
        rise_cyc[k] = cyc;
      end
      if (ovr_w[k]) ovr_cnt[k]++;
      vprev[k] = valid_w[k];
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int t_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Parity bit a correct transmitter sends: odd -> total ones odd, even -> even.
  function automatic logic model_par(input logic [8:0] d, input int n, input int pm);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    return (pm == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic logic model_perr(input logic [8:0] d, input int n, input int pm, input logic p);
    int ones;
    ones = int'(p);
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    if (pm == 0) return 1'b0;
    return (pm == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic drive_bit(input int idx, input logic b);
    rx[idx] = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int idx, input logic [8:0] d, input int n, input int pm,
                            input logic pbit, input logic [1:0] stops, input int nstop);
    rx[idx] = 1'b0;
    t_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < n; i++) drive_bit(idx, d[i]);
    if (pm != 0) drive_bit(idx, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(idx, stops[i]);
  endtask

  initial begin
    logic [8:0] w;
    logic       p;
    logic       flip;
    int         base;
    int         base_o;

    rst   = 1'b0;
    rx    = 3'b111;
    ready = 3'b000;
    repeat (5) @(negedge clk);
    check("rst_flags_def", {valid_w[0], fe_w[0], pe_w[0], ovr_w[0], busy_w[0]}, 0);
    check("rst_data_def", d0, 0);
    check("rst_flags_stop2", {valid_w[2], fe_w[2], pe_w[2], ovr_w[2], busy_w[2]}, 0);
    rst   = 1'b1;
    ready = 3'b111;
    repeat (2 * CPB) @(negedge clk);

    // Basic 0x47 frame with ready held high.
    base = vrise[0];
    send_frame(0, 9'h047, 8, 0, 1'b0, 2'b11, 1);
    repeat (2 * CPB) @(negedge clk);
    check("t1_valid_pulses", vrise[0] - base, 1);
    check("t1_data", cap_data[0], 9'h047);
    check("t1_frame_err", cap_fe[0], 0);
    check("t1_parity_err", cap_pe[0], 0);
    check("t1_valid_low_after", valid_w[0], 0);
    check("t1_latency_window",
          ((rise_cyc[0] - t_start) >= C_LAT - 2) && ((rise_cyc[0] - t_start) <= C_LAT + 2), 1);

    // Back-to-back frames with the consumer stalled.
    ready[0] = 1'b0;
    base   = vrise[0];
    base_o = ovr_cnt[0];
    send_frame(0, 9'h047, 8, 0, 1'b0, 2'b11, 1);
    repeat (CPB) @(negedge clk);
    send_frame(0, 9'h047, 8, 0, 1'b0, 2'b11, 1);
    repeat (2 * CPB) @(negedge clk);
    check("t2_overrun_once", ovr_cnt[0] - base_o, 1);
    check("t2_valid_held", valid_w[0], 1);
    check("t2_data_held", d0, 8'h47);
    check("t2_one_word", vrise[0] - base, 1);
    send_frame(0, 9'h0B8, 8, 0, 1'b0, 2'b11, 1);
    repeat (2 * CPB) @(negedge clk);
    check("t2_overrun_third", ovr_cnt[0] - base_o, 2);
    check("t2_data_not_replaced", d0, 8'h47);
    ready[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_accept_clears_valid", valid_w[0], 0);
    check("t2_data_holds_after_accept", d0, 8'h47);

    // Glitch shorter than half a bit is rejected.
    base = vrise[0];
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_busy_in_start", busy_w[0], 1);
    repeat (20) @(negedge clk);
    check("t3_busy_returned", busy_w[0], 0);
    check("t3_no_valid", vrise[0] - base, 0);
    check("t3_valid_low", valid_w[0], 0);
    check("t3_flags_low", {fe_w[0], pe_w[0]}, 0);

    // Random words on the default receiver.
    for (int i = 0; i < 6; i++) begin
      w    = 9'($urandom_range(0, 255));
      base = vrise[0];
      send_frame(0, w, 8, 0, 1'b0, 2'b11, 1);
      repeat (CPB) @(negedge clk);
      check("rand_def_count", vrise[0] - base, 1);
      check("rand_def_data", cap_data[0], w);
    end

    // Even parity, 7 data bits: wrong parity bit, then a correct one.
    base = vrise[1];
    send_frame(1, 9'h055, 7, 2, 1'b1, 2'b11, 1);
    repeat (CPB) @(negedge clk);
    check("t4_count", vrise[1] - base, 1);
    check("t4_data", cap_data[1], 9'h055);
    check("t4_parity_err", cap_pe[1], 1);
    check("t4_frame_err", cap_fe[1], 0);
    for (int i = 0; i < 6; i++) begin
      w    = 9'($urandom_range(0, 127));
      flip = 1'($urandom_range(0, 1));
      p    = model_par(w, 7, 2) ^ flip;
      send_frame(1, w, 7, 2, p, 2'b11, 1);
      repeat (CPB) @(negedge clk);
      check("rand_par_data", cap_data[1], w);
      check("rand_par_err", cap_pe[1], model_perr(w, 7, 2, p));
    end

    // Two stop bits, second one low, then a long break.
    base = vrise[2];
    send_frame(2, 9'h096, 8, 0, 1'b0, 2'b01, 2);
    repeat (40 * CPB) @(negedge clk);
    check("t5_one_valid", vrise[2] - base, 1);
    check("t5_frame_err", cap_fe[2], 1);
    check("t5_data", cap_data[2], 9'h096);
    check("t5_busy_in_break", busy_w[2], 1);
    rx[2] = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_break_released", busy_w[2], 0);
    repeat (CPB) @(negedge clk);
    send_frame(2, 9'h0A3, 8, 0, 1'b0, 2'b11, 2);
    repeat (CPB) @(negedge clk);
    check("t5_clean_count", vrise[2] - base, 2);
    check("t5_clean_data", cap_data[2], 9'h0A3);
    check("t5_clean_fe", cap_fe[2], 0);

    // Reset in the middle of the data bits.
    base = vrise[0];
    rx[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    rst   = 1'b0;
    rx[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_reset_outputs", {valid_w[0], fe_w[0], pe_w[0], ovr_w[0], busy_w[0]}, 0);
    check("t6_reset_data", d0, 0);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t6_no_partial", vrise[0] - base, 0);
    check("t6_idle_after_reset", busy_w[0], 0);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1);
    repeat (2 * CPB) @(negedge clk);
    check("t6_count", vrise[0] - base, 1);
    check("t6_data", cap_data[0], 9'h03C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
